// File: rtl/mpr_slot_allocator.sv
// Slot allocator for the MPR slot array: grants free slots on context-save requests,
// tracks the outstanding miss per slot and sequences round-robin restores.
//   state       | meaning
//   S_FREE      | slot unused, allocatable
//   S_WAIT_MEM  | context saved, waiting for the miss address to return
//   S_READY     | memory returned, waiting for a restore offer
//   S_RESTORING | offered to the pipeline restore path
module mpr_slot_allocator #(
    parameter int NUM_SLOTS = 4,
    parameter int ADDR_W = 32,
    localparam int IDX_W = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sw_req,
    input  logic [ADDR_W-1:0]    sw_addr,
    output logic                 sw_stall,
    output logic                 sw_grant,
    output logic [IDX_W-1:0]     sw_slot,
    output logic [NUM_SLOTS-1:0] slot_switch,
    output logic [NUM_SLOTS-1:0] slot_freed,
    input  logic                 mem_resp_valid,
    input  logic [ADDR_W-1:0]    mem_resp_addr,
    output logic                 restore_valid,
    output logic [IDX_W-1:0]     restore_slot,
    input  logic                 restore_ready,
    output logic                 stray_resp,
    output logic [IDX_W:0]       busy_count
);

    typedef enum logic [1:0] {S_FREE, S_WAIT_MEM, S_READY, S_RESTORING} slot_state_e;

    slot_state_e          state_q [NUM_SLOTS];
    slot_state_e          state_d [NUM_SLOTS];
    logic [ADDR_W-1:0]    addr_q  [NUM_SLOTS];
    logic [ADDR_W-1:0]    addr_d  [NUM_SLOTS];
    logic                 grant_q, grant_d;
    logic [IDX_W-1:0]     slot_q, slot_d;
    logic [NUM_SLOTS-1:0] switch_q, switch_d;
    logic [NUM_SLOTS-1:0] freed_q, freed_d;
    logic                 stray_q, stray_d;
    logic                 rv_q, rv_d;
    logic [IDX_W-1:0]     rs_q, rs_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [IDX_W:0]       busy_q, busy_d;

    logic                 alloc_found;
    logic [IDX_W-1:0]     alloc_idx;
    logic                 resp_hit;
    logic                 rr_found;
    logic [IDX_W-1:0]     rr_idx;
    logic [IDX_W-1:0]     cand;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        grant_d     = 1'b0;
        slot_d      = '0;
        switch_d    = '0;
        freed_d     = '0;
        rv_d        = rv_q;
        rs_d        = rs_q;
        last_d      = last_q;
        alloc_found = 1'b0;
        alloc_idx   = '0;
        resp_hit    = 1'b0;
        rr_found    = 1'b0;
        rr_idx      = '0;
        cand        = '0;
        busy_d      = '0;

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (!alloc_found && state_q[i] == S_FREE) begin
                alloc_found = 1'b1;
                alloc_idx   = IDX_W'(i);
            end
        end
        if (sw_req && alloc_found) begin
            state_d[alloc_idx]  = S_WAIT_MEM;
            addr_d[alloc_idx]   = sw_addr;
            grant_d             = 1'b1;
            slot_d              = alloc_idx;
            switch_d[alloc_idx] = 1'b1;
        end

        // Only addresses latched before this cycle can match; a same-cycle allocation is still FREE here.
        if (mem_resp_valid) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (state_q[i] == S_WAIT_MEM && addr_q[i] == mem_resp_addr) begin
                    state_d[i] = S_READY;
                    resp_hit   = 1'b1;
                end
            end
        end
        stray_d = mem_resp_valid && !resp_hit;

        if (rv_q && restore_ready) begin
            state_d[rs_q] = S_FREE;
            freed_d[rs_q] = 1'b1;
            rv_d          = 1'b0;
            last_d        = rs_q;
        end else if (!rv_q) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                cand = IDX_W'((int'(last_q) + 1 + i) % NUM_SLOTS);
                if (!rr_found && state_q[cand] == S_READY) begin
                    rr_found = 1'b1;
                    rr_idx   = cand;
                end
            end
            if (rr_found) begin
                state_d[rr_idx] = S_RESTORING;
                rv_d            = 1'b1;
                rs_d            = rr_idx;
            end
        end

        for (int i = 0; i < NUM_SLOTS; i++) begin
            if (state_d[i] != S_FREE) busy_d = busy_d + (IDX_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= '{default: S_FREE};
            addr_q   <= '{default: '0};
            grant_q  <= 1'b0;
            slot_q   <= '0;
            switch_q <= '0;
            freed_q  <= '0;
            stray_q  <= 1'b0;
            rv_q     <= 1'b0;
            rs_q     <= '0;
            last_q   <= '0;
            busy_q   <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            grant_q  <= grant_d;
            slot_q   <= slot_d;
            switch_q <= switch_d;
            freed_q  <= freed_d;
            stray_q  <= stray_d;
            rv_q     <= rv_d;
            rs_q     <= rs_d;
            last_q   <= last_d;
            busy_q   <= busy_d;
        end
    end

    assign sw_stall      = ~alloc_found;
    assign sw_grant      = grant_q;
    assign sw_slot       = slot_q;
    assign slot_switch   = switch_q;
    assign slot_freed    = freed_q;
    assign stray_resp    = stray_q;
    assign restore_valid = rv_q;
    assign restore_slot  = rs_q;
    assign busy_count    = busy_q;

endmodule

// File: tb/tb_mpr_slot_allocator.sv
// Scoreboard bench for mpr_slot_allocator: a slot-level reference model predicts each
// cycle's outputs; a monitor compares them, plus directed checks of the main scenarios.
module tb_mpr_slot_allocator;
    localparam int N = 4;
    localparam int AW = 32;
    localparam int IW = $clog2(N);
    localparam int EW = 1 + 1 + IW + N + N + 1 + IW + 1 + IW + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sw_req = 1'b0;
    logic [AW-1:0] sw_addr = '0;
    logic          sw_stall;
    logic          sw_grant;
    logic [IW-1:0] sw_slot;
    logic [N-1:0]  slot_switch;
    logic [N-1:0]  slot_freed;
    logic          mem_resp_valid = 1'b0;
    logic [AW-1:0] mem_resp_addr = '0;
    logic          restore_valid;
    logic [IW-1:0] restore_slot;
    logic          restore_ready = 1'b0;
    logic          stray_resp;
    logic [IW:0]   busy_count;

    mpr_slot_allocator #(.NUM_SLOTS(N), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .sw_req(sw_req), .sw_addr(sw_addr), .sw_stall(sw_stall),
        .sw_grant(sw_grant), .sw_slot(sw_slot),
        .slot_switch(slot_switch), .slot_freed(slot_freed),
        .mem_resp_valid(mem_resp_valid), .mem_resp_addr(mem_resp_addr),
        .restore_valid(restore_valid), .restore_slot(restore_slot),
        .restore_ready(restore_ready), .stray_resp(stray_resp),
        .busy_count(busy_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: one lifecycle value and address per slot.
    typedef enum int {M_FREE, M_WAIT, M_READY, M_REST} mst_e;
    mst_e          m_st [N];
    logic [AW-1:0] m_addr [N];
    bit            m_offer = 0;
    int            m_rslot = 0;
    int            m_last = 0;
    logic [EW-1:0] exp_q [$];

    task automatic model_step(bit r, bit req, logic [AW-1:0] a, bit rv, logic [AW-1:0] ra, bit rdy);
        mst_e nxt [N];
        int ff, c, busy;
        bit hit, g, st, stall;
        int gs;
        logic [N-1:0] sw, fr;
        sw = '0; fr = '0; g = 0; gs = 0; st = 0; hit = 0; busy = 0; stall = 1;
        if (r) begin
            for (int i = 0; i < N; i++) begin m_st[i] = M_FREE; m_addr[i] = '0; end
            m_offer = 0; m_rslot = 0; m_last = 0;
            exp_q.push_back('0);
            return;
        end
        nxt = m_st;
        ff = -1;
        for (int i = N - 1; i >= 0; i--) if (m_st[i] == M_FREE) ff = i;
        if (rv)
            for (int i = 0; i < N; i++)
                if (m_st[i] == M_WAIT && m_addr[i] == ra) begin nxt[i] = M_READY; hit = 1; end
        st = rv && !hit;
        if (req && ff >= 0) begin
            nxt[ff] = M_WAIT; m_addr[ff] = a; g = 1; gs = ff; sw[ff] = 1'b1;
        end
        if (m_offer && rdy) begin
            nxt[m_rslot] = M_FREE; fr[m_rslot] = 1'b1; m_offer = 0; m_last = m_rslot;
        end else if (!m_offer) begin
            for (int k = 1; k <= N; k++) begin
                c = (m_last + k) % N;
                if (m_st[c] == M_READY) begin
                    nxt[c] = M_REST; m_offer = 1; m_rslot = c;
                    break;
                end
            end
        end
        m_st = nxt;
        for (int i = 0; i < N; i++) begin
            if (m_st[i] != M_FREE) busy++;
            else stall = 0;
        end
        exp_q.push_back({stall, g, IW'(gs), sw, fr, m_offer, IW'(m_rslot), st, (IW+1)'(busy)});
    endtask

    // Monitor: every pushed prediction is compared just after the edge it describes.
    always @(posedge clk) begin
        logic [EW-1:0] e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("scoreboard", 32'({sw_stall, sw_grant, sw_slot, slot_switch, slot_freed,
                                  restore_valid, restore_slot, stray_resp, busy_count}), 32'(e));
        end
    end

    task automatic step(bit r, bit req, logic [AW-1:0] a, bit rv, logic [AW-1:0] ra, bit rdy);
        @(negedge clk);
        rst = r; sw_req = req; sw_addr = a;
        mem_resp_valid = rv; mem_resp_addr = ra; restore_ready = rdy;
        model_step(r, req, a, rv, ra, rdy);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(0, 0, '0, 0, '0, 0);
    endtask

    logic [AW-1:0] pool [5];

    initial begin
        pool[0] = 32'h1000; pool[1] = 32'h2000; pool[2] = 32'h3000;
        pool[3] = 32'h4000; pool[4] = 32'h9999;

        step(1, 0, '0, 0, '0, 0);
        step(1, 0, '0, 0, '0, 0);
        chk("reset_busy", 32'(busy_count), 0);
        chk("reset_stall", 32'(sw_stall), 0);
        chk("reset_rv", 32'(restore_valid), 0);

        step(0, 1, 32'h1000, 0, '0, 0);
        chk("first_grant", 32'(sw_grant), 1);
        chk("first_slot", 32'(sw_slot), 0);
        chk("first_switch", 32'(slot_switch), 32'b0001);
        chk("first_busy", 32'(busy_count), 1);
        step(0, 1, 32'h2000, 0, '0, 0);
        chk("b2b_slot1", 32'(sw_slot), 1);
        step(0, 1, 32'h3000, 0, '0, 0);
        chk("b2b_slot2", 32'(sw_slot), 2);
        step(0, 1, 32'h4000, 0, '0, 0);
        chk("b2b_slot3", 32'(sw_slot), 3);
        chk("full_stall", 32'(sw_stall), 1);
        step(0, 1, 32'h5000, 0, '0, 0);
        chk("full_nogrant", 32'(sw_grant), 0);
        chk("full_busy", 32'(busy_count), 4);

        step(0, 0, '0, 1, 32'h3000, 0);
        idle();
        chk("offer2_valid", 32'(restore_valid), 1);
        chk("offer2_slot", 32'(restore_slot), 2);
        step(0, 0, '0, 1, 32'h1000, 0);
        step(0, 0, '0, 1, 32'h4000, 0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("hold_slot", 32'(restore_slot), 2);
        end
        step(0, 0, '0, 0, '0, 1);
        chk("freed2", 32'(slot_freed), 32'b0100);
        chk("freed2_busy", 32'(busy_count), 3);
        chk("freed2_rv", 32'(restore_valid), 0);
        idle();
        chk("rr_slot3", 32'(restore_slot), 3);
        step(0, 0, '0, 0, '0, 1);
        chk("freed3", 32'(slot_freed), 32'b1000);
        idle();
        chk("rr_slot0", 32'(restore_slot), 0);
        step(0, 0, '0, 0, '0, 1);
        chk("freed0", 32'(slot_freed), 32'b0001);

        step(0, 1, 32'h2000, 0, '0, 0);
        chk("dup_slot", 32'(sw_slot), 0);
        step(0, 0, '0, 1, 32'h2000, 0);
        chk("dup_busy", 32'(busy_count), 2);
        step(0, 0, '0, 1, 32'h9999, 0);
        chk("stray", 32'(stray_resp), 1);
        chk("dup_offer", 32'(restore_slot), 1);

        step(0, 1, 32'h6000, 0, '0, 0);
        step(0, 1, 32'h7000, 0, '0, 0);
        chk("all_busy_stall", 32'(sw_stall), 1);
        step(0, 1, 32'h8000, 0, '0, 1);
        chk("accept_nogrant", 32'(sw_grant), 0);
        chk("accept_freed1", 32'(slot_freed), 32'b0010);
        step(0, 1, 32'h8000, 0, '0, 0);
        chk("retry_grant", 32'(sw_grant), 1);
        chk("retry_slot", 32'(sw_slot), 1);

        step(0, 0, '0, 0, '0, 1);
        step(0, 0, '0, 1, 32'h6000, 0);
        idle();
        chk("pre_rst_busy", 32'(busy_count), 3);
        chk("pre_rst_rv", 32'(restore_valid), 1);
        step(1, 0, '0, 0, '0, 1);
        chk("rst_busy", 32'(busy_count), 0);
        chk("rst_rv", 32'(restore_valid), 0);
        chk("rst_freed", 32'(slot_freed), 0);

        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 2) == 0, pool[$urandom_range(0, 4)],
                 $urandom_range(0, 2) == 0, pool[$urandom_range(0, 4)],
                 $urandom_range(0, 1) == 1);
        end

        @(posedge clk);
        #3;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
